// File: rtl/multibyte_add_ctrl_pkg.sv
// Shared definitions for the byte-serial adder sequencer: FSM encoding and slice width.
package multibyte_add_ctrl_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/multibyte_add_ctrl_add8_slice.sv
// 8-bit ripple-carry adder slice, time-shared by the sequencer one byte per cycle.
module add8_slice
   import multibyte_add_ctrl_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   always_comb begin : ripple
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/multibyte_add_ctrl.sv
// Byte-serial W-bit adder sequencer: one add8_slice reused LSB byte first, carry held between bytes.
// Define ADD_CTRL_OVF_EN to add the signed-overflow output ovf.
//
// state  | meaning
// S_IDLE | waiting for start; result of the last operation held
// S_RUN  | one byte added per cycle, idx selects the byte in flight
// S_DONE | result valid, done pulse for this single cycle
module multibyte_add_ctrl
   import multibyte_add_ctrl_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BYTE_W*WORDS-1:0] a,
   input  logic [BYTE_W*WORDS-1:0] b,
   input  logic                  cin,
   output logic [BYTE_W*WORDS-1:0] sum,
   output logic                  cout,
   output logic                  busy,
   output logic                  done
`ifdef ADD_CTRL_OVF_EN
   ,
   output logic                  ovf
`endif
);

   localparam int W     = BYTE_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx;
   logic [W-1:0]       a_sh, b_sh;
   logic               carry;
   logic [BYTE_W-1:0]  slice_sum;
   logic               slice_cout;
   logic               last_byte;

   add8_slice u_slice (
      .a    (a_sh[BYTE_W-1:0]),
      .b    (b_sh[BYTE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign last_byte = (idx == IDX_W'(WORDS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (last_byte) state_d = S_DONE;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Byte results enter sum at the MSB end so byte 0 lands at the LSB after WORDS shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef ADD_CTRL_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
`ifdef ADD_CTRL_OVF_EN
                  ovf   <= 1'b0;
`endif
               end
            end
            S_RUN: begin
               sum   <= {slice_sum, sum[W-1:BYTE_W]};
               carry <= slice_cout;
               a_sh  <= a_sh >> BYTE_W;
               b_sh  <= b_sh >> BYTE_W;
               if (last_byte) begin
                  idx  <= '0;
                  cout <= slice_cout;
`ifdef ADD_CTRL_OVF_EN
                  // carry into bit 7 recovered from the operand and sum bits
                  ovf  <= (a_sh[BYTE_W-1] ^ b_sh[BYTE_W-1] ^ slice_sum[BYTE_W-1]) ^ slice_cout;
`endif
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Self-checking bench for multibyte_add_ctrl (WORDS=4) against a plain a+b+cin reference model.
module tb_multibyte_add_ctrl;

   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a, b;
   logic          cin;
   logic [W-1:0]  sum;
   logic          cout, busy, done;
`ifdef ADD_CTRL_OVF_EN
   logic          ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   multibyte_add_ctrl #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
`ifdef ADD_CTRL_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin);
      logic [W:0] ref_r;
      int n;
      int cnt0;
      logic ref_ovf;
      ref_r   = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tcin);
      ref_ovf = (ta[W-1] == tb_[W-1]) && (ref_r[W-1] != ta[W-1]);
      cnt0    = done_cnt;
      check("idle_before", {63'b0, busy}, 64'd0);
      start = 1'b1; a = ta; b = tb_; cin = tcin;
      @(negedge clk); n = 1;
      start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
      check("busy_run", {63'b0, busy}, 64'd1);
      @(negedge clk); n = 2;
      start = 1'b1; a = '1; b = $urandom;
      @(negedge clk); n = 3;
      start = 1'b0;
      while (!done && n < WORDS + 12) begin
         @(negedge clk); n++;
      end
      check("done_cycle", 64'(n), 64'(WORDS + 1));
      check("result", {31'b0, cout, sum}, {31'b0, ref_r});
`ifdef ADD_CTRL_OVF_EN
      check("ovf", {63'b0, ovf}, {63'b0, ref_ovf});
`endif
      @(negedge clk);
      #1;
      check("done_single", {63'b0, done}, 64'd0);
      check("busy_after", {63'b0, busy}, 64'd0);
      check("done_count", 64'(done_cnt - cnt0), 64'd1);
      check("held", {31'b0, cout, sum}, {31'b0, ref_r});
   endtask

   initial begin
      logic [W:0] held_r;
      int cnt0;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #1;
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_res", {31'b0, cout, sum}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
      run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
      run_op(32'h00000019, 32'h0000000B, 1'b1);
      held_r = {cout, sum};
      repeat (10) @(negedge clk);
      check("idle_hold", {31'b0, cout, sum}, 64'h25);
      check("idle_hold_r", {31'b0, cout, sum}, {31'b0, held_r});
      check("idle_busy", {63'b0, busy}, 64'd0);
      run_op(32'h1, 32'h1, 1'b0);

      // reset mid-RUN aborts the operation without a done pulse
      @(negedge clk);
      cnt0 = done_cnt;
      start = 1'b1; a = 32'h12345678; b = 32'hFFFFFFFF; cin = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_done", {63'b0, done}, 64'd0);
      check("abort_res", {31'b0, cout, sum}, 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt - cnt0), 64'd0);
      @(negedge clk);
      run_op(32'hDEADBEEF, 32'h21524111, 1'b0);

      // start held together with reset: reset wins
      rst = 1'b1; start = 1'b1; a = 32'h5; b = 32'h6;
      @(negedge clk);
      check("rst_start_busy", {63'b0, busy}, 64'd0);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("rst_start_idle", {63'b0, busy}, 64'd0);

`ifdef ADD_CTRL_OVF_EN
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
      check("ovf_pos", {63'b0, ovf}, 64'd1);
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
      check("ovf_wrap", {63'b0, ovf}, 64'd0);
      run_op(32'h80000000, 32'h80000000, 1'b0);
`endif

      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      run_op(32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 7 == 0) rb = ~ra;
         run_op(ra, rb, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
